// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing one memory bus between instruction fetch and the memory stage.
// The granted request is held on the bus until data_ok, and only the owner sees the response.
package mem_bus_pkg;
  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int D_PRIORITY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  oreq,
  input  dbus_resp_t oresp
);
  // state  | meaning
  // IDLE   | bus free, arbitrate on current requests
  // BUSY_I | fetch request held on the bus until data_ok
  // BUSY_D | memory-stage request held on the bus until data_ok
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic D_FIRST = (D_PRIORITY != 0);

  state_t    state, state_next;
  logic      last;
  dbus_req_t held;
  logic      grant_i, grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b0;
      held  <= '0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        held       <= dreq;
        held.valid <= 1'b1;
      end else if (grant_i) begin
        held.valid  <= 1'b1;
        held.addr   <= ireq.addr;
        held.size   <= MSIZE4;
        held.strobe <= '0;
        held.data   <= '0;
      end
      if (state != IDLE && oresp.data_ok) last <= (state == BUSY_D);
    end
  end

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, round-robin hands the grant to whoever was not served last.
        if (dreq.valid && (!ireq.valid || D_FIRST || !last)) grant_d = 1'b1;
        else if (ireq.valid) grant_i = 1'b1;
        if (grant_d) state_next = BUSY_D;
        else if (grant_i) state_next = BUSY_I;
      end
      BUSY_I, BUSY_D: if (oresp.data_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    oreq  = '0;
    iresp = '0;
    dresp = '0;
    if (state != IDLE) begin
      oreq       = held;
      oreq.valid = 1'b1;
    end
    case (state)
      BUSY_I: begin
        iresp.addr_ok = oresp.addr_ok;
        iresp.data_ok = oresp.data_ok;
        if (oresp.data_ok) iresp.data = held.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
      end
      BUSY_D: begin
        dresp.addr_ok = oresp.addr_ok;
        dresp.data_ok = oresp.data_ok;
        if (oresp.data_ok) dresp.data = oresp.data;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: one instance per tie policy on shared stimulus, each checked
// every cycle against a transaction-level owner/last model, plus directed literal checks.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  dbus_req_t  dreq;
  dbus_resp_t oresp;

  ibus_resp_t iresp_a [2];
  dbus_resp_t dresp_a [2];
  dbus_req_t  oreq_a  [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.D_PRIORITY(1)) u_dpri (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp_a[0]),
    .dreq(dreq), .dresp(dresp_a[0]), .oreq(oreq_a[0]), .oresp(oresp));

  mem_bus_arbiter #(.D_PRIORITY(0)) u_rr (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp_a[1]),
    .dreq(dreq), .dresp(dresp_a[1]), .oreq(oreq_a[1]), .oresp(oresp));

  task automatic chk(input string name, input logic [139:0] got, input logic [139:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction-level model: who owns the bus (0 none, 1 fetch, 2 memory), what was captured,
  // and who was served last.
  int        own  [2] = '{0, 0};
  bit        last [2] = '{1'b0, 1'b0};
  dbus_req_t cap  [2];
  bit        pri  [2] = '{1'b1, 1'b0};

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        own[i]  = 0;
        last[i] = 1'b0;
      end else if (own[i] == 0) begin
        if (dreq.valid && (!ireq.valid || pri[i] || !last[i])) begin
          own[i] = 2;
          cap[i] = dreq;
          cap[i].valid = 1'b1;
        end else if (ireq.valid) begin
          own[i] = 1;
          cap[i] = '{valid: 1'b1, addr: ireq.addr, size: MSIZE4, strobe: 8'h00, data: 64'h0};
        end
      end else if (oresp.data_ok) begin
        last[i] = (own[i] == 2);
        own[i]  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        dbus_req_t  eo;
        ibus_resp_t ei;
        dbus_resp_t ed;
        eo = '0; ei = '0; ed = '0;
        if (own[i] != 0) eo = cap[i];
        if (own[i] == 1) begin
          ei.addr_ok = oresp.addr_ok;
          ei.data_ok = oresp.data_ok;
          if (oresp.data_ok) ei.data = cap[i].addr[2] ? oresp.data[63:32] : oresp.data[31:0];
        end
        if (own[i] == 2) begin
          ed.addr_ok = oresp.addr_ok;
          ed.data_ok = oresp.data_ok;
          if (oresp.data_ok) ed.data = oresp.data;
        end
        chk($sformatf("oreq[%0d] cyc %0d", i, cyc), oreq_a[i], eo);
        chk($sformatf("iresp[%0d] cyc %0d", i, cyc), iresp_a[i], ei);
        chk($sformatf("dresp[%0d] cyc %0d", i, cyc), dresp_a[i], ed);
      end
    end
  end

  // Grant log taken from the DUT bus side: address and cycle of each new grant.
  logic [63:0] ga [2][$];
  int          gc [2][$];
  bit          pv [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (oreq_a[i].valid && !pv[i]) begin
        ga[i].push_back(oreq_a[i].addr);
        gc[i].push_back(cyc);
      end
      pv[i] = oreq_a[i].valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      ga[i].delete();
      gc[i].delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset oreq", oreq_a[0], 0);
    chk("reset iresp", iresp_a[1], 0);
    step();
    reset = 1'b0;

    // Reset while BUSY_D with the bus stalled; a late data_ok must be dropped.
    dreq = '{valid: 1'b1, addr: 64'h40, size: MSIZE8, strobe: 8'hFF, data: 64'h55};
    step();
    @(negedge clk);
    chk("busy_d before reset", oreq_a[0].valid, 1);
    reset = 1'b1;
    dreq.valid = 1'b0;
    step();
    reset = 1'b0;
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h1234};
    @(negedge clk);
    chk("post-reset oreq.valid", oreq_a[0].valid, 0);
    chk("late dresp.data_ok", dresp_a[0].data_ok, 0);
    chk("late iresp.data_ok", iresp_a[0].data_ok, 0);
    step();
    oresp = '0;
    step();

    // Lone fetch; the fetch address moves mid-transaction and must not leak onto the bus.
    ireq = '{valid: 1'b1, addr: 64'h8000_0004};
    step();
    @(negedge clk);
    chk("fetch size", oreq_a[0].size, MSIZE4);
    chk("fetch strobe", oreq_a[0].strobe, 0);
    chk("fetch addr", oreq_a[0].addr, 64'h8000_0004);
    chk("fetch iresp idle", iresp_a[0].data_ok, 0);
    ireq.addr = 64'hFFF0;
    step();
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hDEAD_BEEF_0000_0013};
    @(negedge clk);
    chk("fetch addr held", oreq_a[0].addr, 64'h8000_0004);
    chk("fetch data", iresp_a[0].data, 32'hDEADBEEF);
    chk("fetch data_ok", iresp_a[0].data_ok, 1);
    chk("fetch dresp", dresp_a[0], 0);
    step();
    oresp = '0;
    ireq.valid = 1'b0;
    @(negedge clk);
    chk("fetch data_ok once", iresp_a[0].data_ok, 0);
    step();

    // Lone store with a 3-cycle bus stall.
    dreq = '{valid: 1'b1, addr: 64'h10, size: MSIZE8, strobe: 8'hFF, data: 64'h1122_3344_5566_7788};
    step();
    dreq.valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hCAFE};
      @(negedge clk);
      chk($sformatf("store oreq k%0d", k), oreq_a[0],
          {1'b1, 64'h10, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788});
      chk($sformatf("store data_ok k%0d", k), dresp_a[0].data_ok, (k == 3) ? 1 : 0);
      step();
    end
    oresp = '0;
    step();

    // Tie with both held valid and a bus that answers at once.
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_logs();
    ireq  = '{valid: 1'b1, addr: 64'h100};
    dreq  = '{valid: 1'b1, addr: 64'h200, size: MSIZE8, strobe: 8'h0F, data: 64'h9};
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h7777_8888_9999_AAAA};
    repeat (12) step();
    chk("dpri grant count", ga[0].size() >= 4, 1);
    chk("rr grant count", ga[1].size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dpri grant %0d", k), (ga[0].size() > k) ? ga[0][k] : 64'h0, 64'h200);
      chk($sformatf("rr grant %0d", k), (ga[1].size() > k) ? ga[1][k] : 64'h0,
          (k % 2 == 0) ? 64'h200 : 64'h100);
      if (k > 0)
        chk($sformatf("rr spacing %0d", k), (gc[1].size() > k) ? gc[1][k] - gc[1][k-1] : 0, 2);
    end
    clear_logs();
    dreq.valid = 1'b0;
    repeat (4) step();
    chk("dpri fetch after store", (ga[0].size() > 0) ? ga[0][0] : 64'h0, 64'h100);
    ireq.valid = 1'b0;
    oresp = '0;
    step();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      ireq.valid = ($urandom_range(0, 2) != 0);
      ireq.addr  = {$urandom, $urandom};
      dreq.valid = ($urandom_range(0, 2) != 0);
      dreq.addr  = {$urandom, $urandom};
      dreq.size  = 3'($urandom_range(0, 3));
      dreq.strobe = 8'($urandom);
      dreq.data  = {$urandom, $urandom};
      oresp.addr_ok = 1'($urandom);
      oresp.data_ok = ($urandom_range(0, 2) == 0);
      oresp.data    = {$urandom, $urandom};
      step();
    end
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
